// File: rtl/topk_pkg.sv
// rtl/topk_pkg.sv - shared types and lane mapping for the top-k bitonic front end
package topk_pkg;

    // Tag that travels alongside each issued lane vector
    typedef struct packed {
        logic valid;
        logic last;
    } ctrl_t;

    // Loader fill-buffer states
    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } buf_state_t;

    // Arrival index k -> lane. The upper half is mirrored so the vector enters
    // the sorter already bitonic. The mapping is its own inverse, so the same
    // function also gives the arrival index that owns a given lane.
    function automatic int lane_idx(input int k, input int dl, input bit rev);
        if (rev && (k >= dl / 2)) begin
            return (3 * dl / 2) - 1 - k;
        end
        return k;
    endfunction

endpackage

// File: rtl/bitonic_lane_buf.sv
// rtl/bitonic_lane_buf.sv - fill buffer, element counter and pad mask for the loader
module bitonic_lane_buf
    import topk_pkg::*;
#(
    parameter int DATAWIDTH     = 8,
    parameter int DATALENGTH    = 8,
    parameter int PAD_VALUE     = 0,
    parameter int REVERSE_UPPER = 1
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 i_wr,
    input  logic [DATAWIDTH-1:0] i_data,
    input  logic                 i_last,
    input  logic                 i_xfer,
    output logic                 o_complete,
    output logic                 o_flast,
    output logic [DATAWIDTH-1:0] o_lanes [DATALENGTH-1:0]
);

    localparam int                   CW  = $clog2(DATALENGTH) + 1;
    localparam logic [DATAWIDTH-1:0] PAD = DATAWIDTH'(PAD_VALUE);
    localparam bit                   REV = (REVERSE_UPPER != 0);

    logic [DATAWIDTH-1:0] r_lane [DATALENGTH-1:0];
    logic [CW-1:0]        r_cnt;
    logic                 r_flast;
    buf_state_t           r_state;
    buf_state_t           w_state_nx;
    logic [CW-1:0]        w_base_cnt;
    logic [CW-1:0]        w_cnt_nx;
    logic                 w_flast_nx;

    // Next count/flag/state: a transfer empties the buffer, and a write in the
    // same cycle lands as arrival 0 of the next group
    always_comb begin
        w_base_cnt = i_xfer ? '0 : r_cnt;
        w_cnt_nx   = w_base_cnt;
        w_flast_nx = i_xfer ? 1'b0 : r_flast;
        if (i_wr) begin
            w_cnt_nx   = w_base_cnt + CW'(1);
            w_flast_nx = i_last;
        end
        w_state_nx = ((w_cnt_nx == CW'(DATALENGTH)) || w_flast_nx) ? ST_FULL : ST_FILL;
    end

    // FILL/FULL state register
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Lane storage, count and frame-end flag; reset drops any partial group
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_cnt   <= '0;
            r_flast <= 1'b0;
            for (int i = 0; i < DATALENGTH; i++) begin
                r_lane[i] <= '0;
            end
        end else begin
            r_cnt   <= w_cnt_nx;
            r_flast <= w_flast_nx;
            for (int i = 0; i < DATALENGTH; i++) begin
                if (i_wr && (lane_idx(i, DATALENGTH, REV) == int'(w_base_cnt))) begin
                    r_lane[i] <= i_data;
                end
            end
        end
    end

    // Lanes whose arrival index has not been reached read as the pad value
    always_comb begin
        for (int i = 0; i < DATALENGTH; i++) begin
            o_lanes[i] = (lane_idx(i, DATALENGTH, REV) < int'(r_cnt)) ? r_lane[i] : PAD;
        end
    end

    assign o_complete = (r_state == ST_FULL);
    assign o_flast    = r_flast;

endmodule

// File: rtl/bitonic_8_loader.sv
// rtl/bitonic_8_loader.sv - stream-to-lane-vector loader feeding the bitonic sorter
module bitonic_8_loader
    import topk_pkg::*;
#(
    parameter int DATAWIDTH     = 8,
    parameter int DATALENGTH    = 8,
    parameter int PAD_VALUE     = 0,
    parameter int REVERSE_UPPER = 1
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 s_valid_i,
    output logic                 s_ready_o,
    input  logic [DATAWIDTH-1:0] s_data_i,
    input  logic                 s_last_i,
    output ctrl_t                ctrl_o,
    output logic [DATAWIDTH-1:0] y_o [DATALENGTH-1:0],
    input  logic                 m_ready_i
);

    logic [DATAWIDTH-1:0] r_y [DATALENGTH-1:0];
    ctrl_t                r_ctrl;
    logic [DATAWIDTH-1:0] w_lanes [DATALENGTH-1:0];
    logic                 w_complete;
    logic                 w_flast;
    logic                 w_out_free;
    logic                 w_xfer;
    logic                 w_wr;

    // Output register can take a new vector when empty or being consumed now
    assign w_out_free = !r_ctrl.valid || m_ready_i;
    assign w_xfer     = w_complete && w_out_free;
    assign s_ready_o  = !w_complete || w_out_free;
    assign w_wr       = s_valid_i && s_ready_o;

    bitonic_lane_buf #(
        .DATAWIDTH     (DATAWIDTH),
        .DATALENGTH    (DATALENGTH),
        .PAD_VALUE     (PAD_VALUE),
        .REVERSE_UPPER (REVERSE_UPPER)
    ) u_buf (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .i_wr       (w_wr),
        .i_data     (s_data_i),
        .i_last     (s_last_i),
        .i_xfer     (w_xfer),
        .o_complete (w_complete),
        .o_flast    (w_flast),
        .o_lanes    (w_lanes)
    );

    // Output register: load on transfer, otherwise hold until consumed
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_ctrl <= '0;
            for (int i = 0; i < DATALENGTH; i++) begin
                r_y[i] <= '0;
            end
        end else if (w_xfer) begin
            r_ctrl.valid <= 1'b1;
            r_ctrl.last  <= w_flast;
            for (int i = 0; i < DATALENGTH; i++) begin
                r_y[i] <= w_lanes[i];
            end
        end else if (m_ready_i) begin
            r_ctrl.valid <= 1'b0;
        end
    end

    assign ctrl_o = r_ctrl;
    assign y_o    = r_y;

endmodule

// File: tb/tb_bitonic_8_loader.sv
// tb/tb_bitonic_8_loader.sv - directed self-checking bench for bitonic_8_loader
module tb_bitonic_8_loader;
    import topk_pkg::*;

    logic       clk = 1'b0;
    logic       rstn;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_last;
    logic       m_ready;

    logic       rdy_r, rdy_f;
    ctrl_t      ctrl_r, ctrl_f;
    logic [7:0] y_r [7:0];
    logic [7:0] y_f [7:0];
    logic [63:0] y_r_p, y_f_p;

    int errors = 0;
    int checks = 0;
    int waits  = 0;

    always #5 clk = ~clk;

    bitonic_8_loader #(.DATAWIDTH(8), .DATALENGTH(8), .PAD_VALUE(0), .REVERSE_UPPER(1)) u_rev (
        .clk_i(clk), .rstn_i(rstn), .s_valid_i(s_valid), .s_ready_o(rdy_r),
        .s_data_i(s_data), .s_last_i(s_last), .ctrl_o(ctrl_r), .y_o(y_r), .m_ready_i(m_ready)
    );

    bitonic_8_loader #(.DATAWIDTH(8), .DATALENGTH(8), .PAD_VALUE(0), .REVERSE_UPPER(0)) u_fwd (
        .clk_i(clk), .rstn_i(rstn), .s_valid_i(s_valid), .s_ready_o(rdy_f),
        .s_data_i(s_data), .s_last_i(s_last), .ctrl_o(ctrl_f), .y_o(y_f), .m_ready_i(m_ready)
    );

    assign y_r_p = {y_r[7], y_r[6], y_r[5], y_r[4], y_r[3], y_r[2], y_r[1], y_r[0]};
    assign y_f_p = {y_f[7], y_f[6], y_f[5], y_f[4], y_f[3], y_f[2], y_f[1], y_f[0]};

    function automatic logic [63:0] vec(input int a0, input int a1, input int a2, input int a3,
                                        input int a4, input int a5, input int a6, input int a7);
        return {a7[7:0], a6[7:0], a5[7:0], a4[7:0], a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        #1;
        while (!rdy_r && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        waits += n;
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout observed=ready_low expected=ready_high data=%h", d);
        end
        @(posedge clk);
        #2;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
        cyc(); cyc();
        rstn = 1'b1;
        cyc();
        chk1("rst_valid", ctrl_r.valid, 1'b0);
        chk1("rst_last", ctrl_r.last, 1'b0);
        chk("rst_y", y_r_p, 64'd0);
        chk1("rst_ready", rdy_r, 1'b1);

        // Two full groups streamed back to back, last on the 16th element
        waits = 0;
        for (int k = 0; k < 16; k++) begin
            send(k[7:0], k == 15);
            if (k == 8) begin
                chk1("t1_v0_valid", ctrl_r.valid, 1'b1);
                chk1("t1_v0_last", ctrl_r.last, 1'b0);
                chk("t1_v0_y", y_r_p, vec(0, 1, 2, 3, 7, 6, 5, 4));
                chk("t1_v0_y_fwd", y_f_p, vec(0, 1, 2, 3, 4, 5, 6, 7));
            end
            if (k == 9) chk1("t1_v0_retire", ctrl_r.valid, 1'b0);
        end
        cyc();
        chk1("t1_v1_valid", ctrl_r.valid, 1'b1);
        chk1("t1_v1_last", ctrl_r.last, 1'b1);
        chk("t1_v1_y", y_r_p, vec(8, 9, 10, 11, 15, 14, 13, 12));
        chk("t1_no_stall", 64'(waits), 64'd0);
        cyc();
        chk1("t1_drop", ctrl_r.valid, 1'b0);

        // Short frame padded, forward lane order
        send(8'd9, 1'b0);
        send(8'd5, 1'b0);
        send(8'd7, 1'b1);
        chk1("t2_not_yet", ctrl_f.valid, 1'b0);
        cyc();
        chk1("t2_valid", ctrl_f.valid, 1'b1);
        chk1("t2_last", ctrl_f.last, 1'b1);
        chk("t2_y_fwd", y_f_p, vec(9, 5, 7, 0, 0, 0, 0, 0));
        chk("t2_y_rev", y_r_p, vec(9, 5, 7, 0, 0, 0, 0, 0));
        cyc();
        chk1("t2_drop", ctrl_f.valid, 1'b0);

        // Downstream stall over a 24-element stream
        m_ready = 1'b0;
        for (int k = 0; k < 16; k++) send(8'h20 + k[7:0], 1'b0);
        s_valid = 1'b1; s_data = 8'h30; s_last = 1'b0;
        #1;
        chk1("t3_ready_low", rdy_r, 1'b0);
        repeat (4) cyc();
        chk1("t3_hold_valid", ctrl_r.valid, 1'b1);
        chk("t3_hold_y", y_r_p, vec(8'h20, 8'h21, 8'h22, 8'h23, 8'h27, 8'h26, 8'h25, 8'h24));
        chk1("t3_still_low", rdy_r, 1'b0);
        m_ready = 1'b1;
        #1;
        chk1("t4_ready_hi", rdy_r, 1'b1);
        @(posedge clk);
        #2;
        s_valid = 1'b0;
        chk1("t4_b2b_valid", ctrl_r.valid, 1'b1);
        chk1("t4_b2b_last", ctrl_r.last, 1'b0);
        chk("t4_b2b_y", y_r_p, vec(8'h28, 8'h29, 8'h2a, 8'h2b, 8'h2f, 8'h2e, 8'h2d, 8'h2c));
        for (int k = 17; k < 24; k++) begin
            send(8'h20 + k[7:0], k == 23);
            if (k == 17) chk1("t3_no_dup", ctrl_r.valid, 1'b0);
        end
        cyc();
        chk1("t3_v2_valid", ctrl_r.valid, 1'b1);
        chk1("t3_v2_last", ctrl_r.last, 1'b1);
        chk("t3_v2_y", y_r_p, vec(8'h30, 8'h31, 8'h32, 8'h33, 8'h37, 8'h36, 8'h35, 8'h34));
        cyc();
        chk1("t3_drop", ctrl_r.valid, 1'b0);

        // Reset mid-frame with a vector held in the output register
        m_ready = 1'b0;
        for (int k = 0; k < 8; k++) send(8'h40 + k[7:0], 1'b0);
        cyc();
        chk1("t5_pre_valid", ctrl_r.valid, 1'b1);
        for (int k = 0; k < 5; k++) send(8'h50 + k[7:0], 1'b0);
        rstn = 1'b0;
        cyc();
        rstn = 1'b1;
        chk1("t5_rst_valid", ctrl_r.valid, 1'b0);
        chk("t5_rst_y", y_r_p, 64'd0);
        chk("t5_rst_y_fwd", y_f_p, 64'd0);
        m_ready = 1'b1;
        cyc();
        chk1("t5_ready", rdy_r, 1'b1);
        for (int k = 0; k < 8; k++) send(8'h60 + k[7:0], 1'b0);
        cyc();
        chk1("t5_clean_valid", ctrl_r.valid, 1'b1);
        chk1("t5_clean_last", ctrl_r.last, 1'b0);
        chk("t5_clean_y", y_r_p, vec(8'h60, 8'h61, 8'h62, 8'h63, 8'h67, 8'h66, 8'h65, 8'h64));
        cyc();

        // Single-element frame
        send(8'hab, 1'b1);
        cyc();
        chk1("t6_valid", ctrl_r.valid, 1'b1);
        chk1("t6_last", ctrl_r.last, 1'b1);
        chk("t6_y", y_r_p, vec(8'hab, 0, 0, 0, 0, 0, 0, 0));
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
